// File: rtl/matvec_operand_loader.sv
// matvec_operand_loader: deserialises 16 matrix + 4 vector words into a held operand frame for the 4x4 multiplier
module matvec_operand_loader #(
   parameter int N = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    in_data,
   input  logic            in_valid,
   input  logic            in_last,
   output logic            in_ready,
   input  logic            flush,
   output logic [16*N-1:0] a_flat,
   output logic [4*N-1:0]  x_flat,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      word_idx,
   output logic            frame_err
);
   typedef enum logic {LOAD, HOLD} state_t;
   state_t state;
   assign in_ready = !rst && state == LOAD;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         word_idx  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         a_flat    <= '0;
         x_flat    <= '0;
      end else begin
         frame_err <= 1'b0;
         if (flush) begin
            state     <= LOAD;
            word_idx  <= '0;
            out_valid <= 1'b0;
         end else if (state == HOLD) begin
            if (out_ready) begin
               state     <= LOAD;
               out_valid <= 1'b0;
            end
         end else if (in_valid) begin
            if (word_idx < 5'd16) a_flat[word_idx[3:0]*N +: N] <= in_data;
            else x_flat[word_idx[1:0]*N +: N] <= in_data;
            if (in_last != (word_idx == 5'd19)) begin
               frame_err <= 1'b1;
               word_idx  <= '0;
            end else if (in_last) begin
               state     <= HOLD;
               out_valid <= 1'b1;
               word_idx  <= '0;
            end else begin
               word_idx  <= word_idx + 5'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_matvec_operand_loader.sv
// tb_matvec_operand_loader: vector table, directed corner sequences and random traffic against a frame-level model
module tb_matvec_operand_loader;
   localparam int N = 16;
   logic clk = 1'b0;
   logic rst, in_valid, in_last, flush, out_ready, in_ready, out_valid, frame_err;
   logic [N-1:0] in_data;
   logic [16*N-1:0] a_flat;
   logic [4*N-1:0] x_flat;
   logic [4:0] word_idx;
   int checks = 0;
   int errors = 0;
   logic [N-1:0] m_a [16];
   logic [N-1:0] m_x [4];
   logic [N-1:0] frame [$];
   bit m_hold, m_err;

   matvec_operand_loader #(.N(N)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .flush(flush), .a_flat(a_flat), .x_flat(x_flat),
      .out_valid(out_valid), .out_ready(out_ready), .word_idx(word_idx), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit r, v, l, f, o;
      logic [N-1:0] d;
      logic [4:0] e_idx;
      bit e_ov, e_err, e_rdy;
      logic [N-1:0] e_a1;
   } vec_t;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model works on whole frames: the words collected so far decide position, completion and errors.
   task automatic step(input bit r, input bit v, input bit l, input bit f, input bit o, input logic [N-1:0] d);
      logic [16*N-1:0] ea;
      logic [4*N-1:0] ex;
      int p;
      rst = r; in_valid = v; in_last = l; flush = f; out_ready = o; in_data = d;
      if (r) begin
         foreach (m_a[k]) m_a[k] = '0;
         foreach (m_x[k]) m_x[k] = '0;
         frame.delete();
         m_hold = 0;
         m_err = 0;
      end else begin
         m_err = 0;
         if (f) begin
            frame.delete();
            m_hold = 0;
         end else if (m_hold) begin
            if (o) m_hold = 0;
         end else if (v) begin
            p = frame.size();
            if (p < 16) m_a[p] = d; else m_x[p-16] = d;
            frame.push_back(d);
            if (l || frame.size() == 20) begin
               if (l && frame.size() == 20) m_hold = 1; else m_err = 1;
               frame.delete();
            end
         end
      end
      @(posedge clk);
      #1;
      foreach (m_a[k]) ea[k*N +: N] = m_a[k];
      foreach (m_x[k]) ex[k*N +: N] = m_x[k];
      chk("word_idx", word_idx, frame.size());
      chk("out_valid", out_valid, m_hold);
      chk("frame_err", frame_err, m_err);
      chk("in_ready", in_ready, !r && !m_hold);
      chk("a_flat", a_flat, ea);
      chk("x_flat", x_flat, ex);
   endtask

   task automatic send(input logic [N-1:0] w [20], input int n, input int last_at, input bit tog, input bit o);
      for (int i = 0; i < n; i++) begin
         if (tog) step(0, 0, 0, 0, o, 16'hdead);
         step(0, 1, i == last_at, 0, o, w[i]);
      end
   endtask

   task automatic chk_y(input string name, input int e1, input int e2, input int e3, input int e4);
      int y [4];
      int e [4];
      e = '{e1, e2, e3, e4};
      for (int r = 0; r < 4; r++) begin
         y[r] = 0;
         for (int c = 0; c < 4; c++) y[r] += int'(a_flat[(r*4+c)*N +: N]) * int'(x_flat[c*N +: N]);
         chk(name, y[r], e[r]);
      end
   endtask

   initial begin
      vec_t tbl [9];
      logic [N-1:0] ident [20], anti [20], mixed [20], seq [20];
      logic [16*N-1:0] snap_a;
      logic [4*N-1:0] snap_x;
      tbl[0] = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000};
      tbl[1] = '{0, 1, 0, 0, 0, 16'h0011, 1, 0, 0, 1, 16'h0011};
      tbl[2] = '{0, 0, 0, 0, 0, 16'h00ff, 1, 0, 0, 1, 16'h0011};
      tbl[3] = '{0, 1, 1, 0, 0, 16'h0022, 0, 0, 1, 1, 16'h0011};
      tbl[4] = '{0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0011};
      tbl[5] = '{0, 1, 0, 1, 0, 16'h0033, 0, 0, 0, 1, 16'h0011};
      tbl[6] = '{0, 1, 0, 0, 0, 16'h0044, 1, 0, 0, 1, 16'h0044};
      tbl[7] = '{0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 1, 16'h0044};
      tbl[8] = '{1, 1, 0, 0, 0, 16'h0055, 0, 0, 0, 0, 16'h0000};
      ident = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1, 1,2,3,4};
      anti  = '{0,0,0,1, 0,0,1,0, 0,1,0,0, 1,0,0,0, 1,2,3,4};
      mixed = '{1,0,1,0, 0,1,0,1, 1,0,0,1, 0,1,1,0, 5,10,20,10};
      for (int i = 0; i < 20; i++) seq[i] = N'(16'h100 + i);
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].o, tbl[i].d);
         chk("tbl_idx", word_idx, tbl[i].e_idx);
         chk("tbl_ov", out_valid, tbl[i].e_ov);
         chk("tbl_err", frame_err, tbl[i].e_err);
         chk("tbl_rdy", in_ready, tbl[i].e_rdy);
         chk("tbl_a1", a_flat[N-1:0], tbl[i].e_a1);
      end
      // identity frame, held with out_ready low
      step(1, 0, 0, 0, 0, 0);
      send(ident, 19, 19, 0, 0);
      chk("ov_before_last", out_valid, 0);
      step(0, 1, 1, 0, 0, ident[19]);
      chk("ident_ov", out_valid, 1);
      chk("ident_rdy", in_ready, 0);
      chk("ident_x", x_flat, {16'd4, 16'd3, 16'd2, 16'd1});
      chk_y("ident_y", 1, 2, 3, 4);
      step(0, 0, 0, 0, 1, 0);
      chk("handshake_ov", out_valid, 0);
      // anti-diagonal with gapped valid, then 10 held cycles
      send(anti, 20, 19, 1, 0);
      snap_a = a_flat;
      snap_x = x_flat;
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 0, 0, 0, 16'hbeef);
         chk("hold_a", a_flat, snap_a);
         chk("hold_x", x_flat, snap_x);
         chk("hold_ov", out_valid, 1);
      end
      chk_y("anti_y", 4, 3, 2, 1);
      step(0, 0, 0, 0, 1, 0);
      // early in_last, then a good frame
      send(seq, 8, 7, 0, 0);
      chk("early_err", frame_err, 1);
      chk("early_idx", word_idx, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("early_err_pulse", frame_err, 0);
      chk("early_no_ov", out_valid, 0);
      send(mixed, 20, 19, 0, 0);
      chk_y("mixed_y", 25, 20, 15, 30);
      step(0, 0, 0, 0, 1, 0);
      // missing in_last on word 20
      send(seq, 20, -1, 0, 0);
      chk("nolast_err", frame_err, 1);
      chk("nolast_ov", out_valid, 0);
      step(0, 1, 0, 0, 0, 16'h0777);
      chk("word21_idx", word_idx, 1);
      chk("word21_a1", a_flat[N-1:0], 16'h0777);
      // flush mid-frame and during HOLD
      step(0, 0, 0, 1, 0, 0);
      send(seq, 9, -1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("flush_idx", word_idx, 0);
      chk("flush_err", frame_err, 0);
      send(mixed, 20, 19, 0, 0);
      step(0, 1, 0, 1, 0, 16'h0999);
      chk("flush_hold_ov", out_valid, 0);
      chk("flush_word_ignored", a_flat[N-1:0], 16'h0001);
      // reset mid-frame and in HOLD; out_ready with the final word
      send(seq, 12, -1, 0, 0);
      chk("mid_idx", word_idx, 12);
      step(1, 1, 0, 0, 0, 16'h0abc);
      chk("rst_idx", word_idx, 0);
      chk("rst_rdy", in_ready, 0);
      chk("rst_a", a_flat, 0);
      step(0, 0, 0, 0, 0, 0);
      send(ident, 19, 19, 0, 0);
      step(0, 1, 1, 0, 1, ident[19]);
      chk("early_ordy_ov", out_valid, 1);
      step(1, 0, 0, 0, 0, 0);
      chk("rst_hold_ov", out_valid, 0);
      chk("rst_hold_x", x_flat, 0);
      // random traffic
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
              frame.size() == 19 ? $urandom_range(0, 9) != 0 : $urandom_range(0, 29) == 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, N'($urandom));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
